// File: rtl/spiflash_responder.sv
// spiflash_responder: SPI mode-0 flash slave serving a read-only image from a 1-cycle synchronous ROM.
// Supports read (03), fast read (0B), power-down (B9) and release (AB); pins are oversampled on clk.
module spiflash_responder #(
    parameter int ADDR_W   = 16,
    parameter bit START_PD = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_csb,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              powered_down
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        csb_sync_q, sck_sync_q, mosi_sync_q;
    logic              sck_dly_q;
    logic [4:0]        cnt_q, cnt_d;
    logic [6:0]        cmd_q, cmd_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        sh_q, sh_d;
    logic              fast_q, fast_d, pd_q, pd_d, rd_q, rd_d, load_q;
    logic              miso_q, miso_d, oe_q, oe_d;
    logic              csb_s, mosi_s, rise, fall;
    logic [7:0]        cmd_next;
    logic [ADDR_W-1:0] addr_next;

    assign csb_s        = csb_sync_q[1];
    assign mosi_s       = mosi_sync_q[1];
    assign rise         = sck_sync_q[1] & ~sck_dly_q;
    assign fall         = ~sck_sync_q[1] & sck_dly_q;
    assign cmd_next     = {cmd_q, mosi_s};
    // Only the low ADDR_W address bits survive the shift, which gives the modulo wrap for free.
    assign addr_next    = {addr_q, mosi_s};
    assign spi_miso     = miso_q;
    assign spi_miso_oe  = oe_q;
    assign mem_rd       = rd_q;
    assign mem_addr     = mem_addr_q;
    assign powered_down = pd_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csb_sync_q  <= 2'b11;
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            sck_dly_q   <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            sh_q        <= '0;
            fast_q      <= 1'b0;
            pd_q        <= START_PD;
            rd_q        <= 1'b0;
            load_q      <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            csb_sync_q  <= {csb_sync_q[0], spi_csb};
            sck_sync_q  <= {sck_sync_q[0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_dly_q   <= sck_sync_q[1];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            sh_q        <= sh_d;
            fast_q      <= fast_d;
            pd_q        <= pd_d;
            rd_q        <= rd_d;
            load_q      <= rd_q;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        fast_d     = fast_q;
        pd_d       = pd_q;
        rd_d       = 1'b0;
        sh_d       = load_q ? mem_rdata : sh_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        if (csb_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: if (rise) begin
                    cmd_d = cmd_next[6:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = '0;
                        state_d = IGNORE;
                        if (cmd_next == 8'hAB) begin
                            pd_d = 1'b0;
                        end else if (!pd_q) begin
                            pd_d    = cmd_next == 8'hB9;
                            fast_d  = cmd_next == 8'h0B;
                            state_d = (cmd_next == 8'h03 || cmd_next == 8'h0B) ? ADDR : IGNORE;
                        end
                    end
                end
                ADDR: if (rise) begin
                    addr_d = addr_next[ADDR_W-2:0];
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        cnt_d      = '0;
                        mem_addr_d = addr_next;
                        rd_d       = 1'b1;
                        state_d    = fast_q ? DUMMY : DATA;
                    end
                end
                DUMMY: if (rise) begin
                    cnt_d   = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd7) ? DATA : DUMMY;
                end
                DATA: begin
                    if (fall) begin
                        miso_d = sh_q[7];
                        oe_d   = 1'b1;
                        sh_d   = {sh_q[6:0], 1'b0};
                    end
                    // Last bit of a byte sampled: prefetch the next one so it is loaded before the fall.
                    if (rise) begin
                        cnt_d = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            mem_addr_d = mem_addr_q + ADDR_W'(1);
                            rd_d       = 1'b1;
                        end
                    end
                end
                default: oe_d = 1'b0;
            endcase
        end
    end
endmodule
